// File: rtl/uop_issue_m1_pkg.sv
// uop_issue_m1_pkg: uop, queue-entry and unit types shared by the issue stage.
package uop_issue_m1_pkg;
    localparam int NUM_UNITS = 5;
    // Queue entries carry indices for the default 16-register file.
    localparam int IDX_W = 4;
    typedef struct packed {
        logic [7:0] opcode;
        logic       call_alu;
        logic       call_mul;
        logic       call_div;
        logic       call_lsu;
        logic       call_brh;
        logic       fence_mode;
        logic       rs1_dependency;
        logic       rs2_dependency;
        logic       regfile_write;
    } uop_t;
    typedef enum logic [2:0] {
        ALU = 3'd0, MUL = 3'd1, DIV = 3'd2, LSU = 3'd3, BRH = 3'd4, FENCE = 3'd5, NOP = 3'd6
    } unit_e;
    typedef struct packed {
        uop_t             uop;
        logic [IDX_W-1:0] rd;
        logic [IDX_W-1:0] rs1;
        logic [IDX_W-1:0] rs2;
    } issue_entry_t;
    function automatic unit_e unit_sel(uop_t u);
        return u.call_alu ? ALU : u.call_mul ? MUL : u.call_div ? DIV :
               u.call_lsu ? LSU : u.call_brh ? BRH : u.fence_mode ? FENCE : NOP;
    endfunction
endpackage

// File: rtl/uop_issue_m1_if.sv
// uop_issue_m1_if: decode, dispatch and writeback signals of the issue stage.
interface uop_issue_m1_if import uop_issue_m1_pkg::*; #(parameter int REG_W = 4);
    logic                 dec_valid_in;
    logic                 dec_ready_out;
    uop_t                 dec_uop_in;
    logic [REG_W-1:0]     dec_rd_in, dec_rs1_in, dec_rs2_in;
    logic [NUM_UNITS-1:0] iss_valid_out;
    logic [NUM_UNITS-1:0] unit_ready_in;
    uop_t                 iss_uop_out;
    logic [REG_W-1:0]     iss_rd_out, iss_rs1_out, iss_rs2_out;
    logic [1:0]           wb_valid_in;
    logic [2*REG_W-1:0]   wb_rd_in;
    modport master (
        output dec_valid_in, dec_uop_in, dec_rd_in, dec_rs1_in, dec_rs2_in, unit_ready_in, wb_valid_in, wb_rd_in,
        input  dec_ready_out, iss_valid_out, iss_uop_out, iss_rd_out, iss_rs1_out, iss_rs2_out
    );
    modport slave (
        input  dec_valid_in, dec_uop_in, dec_rd_in, dec_rs1_in, dec_rs2_in, unit_ready_in, wb_valid_in, wb_rd_in,
        output dec_ready_out, iss_valid_out, iss_uop_out, iss_rd_out, iss_rs1_out, iss_rs2_out
    );
endinterface

// File: rtl/uop_issue_m1_sb.sv
// uop_issue_m1_sb: register busy-bit scoreboard with one set port, two clear ports
// and combinational hazard lookup; a set beats a clear of the same register.
module uop_issue_m1_sb #(
    parameter int NREGS    = 16,
    parameter int REG_W    = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en_i,
    input  logic [REG_W-1:0]   set_rd_i,
    input  logic [1:0]         clr_en_i,
    input  logic [2*REG_W-1:0] clr_rd_i,
    input  logic [REG_W-1:0]   rs1_i,
    input  logic [REG_W-1:0]   rs2_i,
    input  logic [REG_W-1:0]   rd_i,
    output logic [NREGS-1:0]   busy_o,
    output logic               rs1_busy_o,
    output logic               rs2_busy_o,
    output logic               rd_busy_o,
    output logic               drained_o
);
    logic [NREGS-1:0] busy_q, busy_d, clr_mask;
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < 2; i++)
            if (clr_en_i[i]) clr_mask[clr_rd_i[i*REG_W +: REG_W]] = 1'b1;
        busy_d = busy_q & ~clr_mask;
        if (set_en_i && !(ZERO_REG && set_rd_i == '0)) busy_d[set_rd_i] = 1'b1;
    end
    // Writebacks landing this cycle already count as retired for the drain check.
    assign drained_o  = (busy_q & ~clr_mask) == '0;
    assign rs1_busy_o = busy_q[rs1_i];
    assign rs2_busy_o = busy_q[rs2_i];
    assign rd_busy_o  = busy_q[rd_i];
    assign busy_o     = busy_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end
endmodule

// File: rtl/uop_issue_m1.sv
// uop_issue_m1: in-order issue queue that dispatches the head uop one-hot to
// ALU/MUL/DIV/LSU/BRH once its operands are free and the unit is ready.
module uop_issue_m1 import uop_issue_m1_pkg::*; #(
    parameter int DEPTH    = 4,
    parameter int NREGS    = 16,
    parameter int REG_W    = $clog2(NREGS),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    input  logic             lsu_idle_in,
    uop_issue_m1_if.slave    bus,
    output logic [NREGS-1:0] busy_out,
    output logic             stall_out
);
    localparam int PW = $clog2(DEPTH);
    issue_entry_t   mem_q [DEPTH];
    issue_entry_t   head, new_entry;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW:0]    count_q, count_d;
    unit_e          unit;
    logic           head_valid, enq, deq, fire;
    logic           rs1_busy, rs2_busy, rd_busy, drained;
    uop_issue_m1_sb #(.NREGS(NREGS), .REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_sb (
        .clk        (clk_in),
        .rst        (rst_in),
        .set_en_i   (fire && head.uop.regfile_write),
        .set_rd_i   (REG_W'(head.rd)),
        .clr_en_i   (bus.wb_valid_in),
        .clr_rd_i   (bus.wb_rd_in),
        .rs1_i      (REG_W'(head.rs1)),
        .rs2_i      (REG_W'(head.rs2)),
        .rd_i       (REG_W'(head.rd)),
        .busy_o     (busy_out),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy),
        .drained_o  (drained)
    );
    always_comb begin
        head       = mem_q[rd_ptr_q];
        unit       = unit_sel(head.uop);
        head_valid = count_q != '0;
        fire       = head_valid && !flush_in && unit < FENCE && bus.unit_ready_in[unit] &&
                     !(head.uop.rs1_dependency && rs1_busy) &&
                     !(head.uop.rs2_dependency && rs2_busy) &&
                     !(head.uop.regfile_write && rd_busy);
        // NOPs retire at once; a FENCE waits for every write and LSU access to finish.
        deq        = fire || (head_valid && !flush_in &&
                     (unit == NOP || (unit == FENCE && drained && lsu_idle_in)));
        bus.dec_ready_out = count_q < (PW+1)'(DEPTH);
        enq        = bus.dec_valid_in && bus.dec_ready_out && !flush_in;
        new_entry  = '{uop: bus.dec_uop_in, rd: IDX_W'(bus.dec_rd_in),
                       rs1: IDX_W'(bus.dec_rs1_in), rs2: IDX_W'(bus.dec_rs2_in)};
        count_d    = flush_in ? '0 : count_q + (PW+1)'(enq) - (PW+1)'(deq);
        rd_ptr_d   = flush_in ? '0 : rd_ptr_q + PW'(deq);
        wr_ptr_d   = flush_in ? '0 : wr_ptr_q + PW'(enq);
        bus.iss_valid_out = fire ? (NUM_UNITS'(1) << unit) : '0;
        bus.iss_uop_out   = head.uop;
        bus.iss_rd_out    = REG_W'(head.rd);
        bus.iss_rs1_out   = REG_W'(head.rs1);
        bus.iss_rs2_out   = REG_W'(head.rs2);
        stall_out  = head_valid && !flush_in && !deq;
    end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (enq) mem_q[wr_ptr_q] <= new_entry;
        end
    end
endmodule

// File: tb/tb_uop_issue_m1.sv
// tb_uop_issue_m1: directed scenarios plus randomized traffic checked against a
// queue-and-busy-vector model of the issue stage.
module tb_uop_issue_m1;
    import uop_issue_m1_pkg::*;
    typedef struct { uop_t uop; logic [3:0] rd, rs1, rs2; } ent_t;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, lsu_idle = 1'b0;
    logic [15:0] busy;
    logic stall;
    int npass = 0, ntot = 0;
    ent_t q[$];
    logic [15:0] mb = '0;
    logic [4:0] e_iss;
    logic e_stall, e_ready, e_deq, e_set;
    logic [3:0] e_setrd;
    uop_issue_m1_if #(.REG_W(4)) bus();
    uop_issue_m1 #(.DEPTH(4), .NREGS(16), .REG_W(4), .ZERO_REG(1'b1)) dut (
        .clk_in(clk), .rst_in(rst), .flush_in(flush), .lsu_idle_in(lsu_idle),
        .bus(bus.slave), .busy_out(busy), .stall_out(stall));
    always #5 clk = ~clk;

    function automatic uop_t mk(int k, bit w, bit d1, bit d2);
        uop_t u = '0;
        u.opcode = 8'($urandom);
        case (k)
            0: u.call_alu = 1'b1;
            1: u.call_mul = 1'b1;
            2: u.call_div = 1'b1;
            3: u.call_lsu = 1'b1;
            4: u.call_brh = 1'b1;
            5: u.fence_mode = 1'b1;
            default: ;
        endcase
        u.regfile_write = w; u.rs1_dependency = d1; u.rs2_dependency = d2;
        return u;
    endfunction
    function automatic uop_t rand_uop();
        uop_t u = '0;
        u.opcode = 8'($urandom);
        u.call_alu = $urandom_range(0, 3) == 0; u.call_mul = $urandom_range(0, 3) == 0;
        u.call_div = $urandom_range(0, 3) == 0; u.call_lsu = $urandom_range(0, 3) == 0;
        u.call_brh = $urandom_range(0, 3) == 0; u.fence_mode = $urandom_range(0, 3) == 0;
        u.rs1_dependency = 1'($urandom); u.rs2_dependency = 1'($urandom); u.regfile_write = 1'($urandom);
        return u;
    endfunction
    function automatic int kind_of(uop_t u);
        if (u.call_alu) return 0;
        if (u.call_mul) return 1;
        if (u.call_div) return 2;
        if (u.call_lsu) return 3;
        if (u.call_brh) return 4;
        if (u.fence_mode) return 5;
        return 6;
    endfunction

    task automatic quiet();
        bus.dec_valid_in = 1'b0; bus.dec_uop_in = '0; bus.dec_rd_in = '0; bus.dec_rs1_in = '0; bus.dec_rs2_in = '0;
        bus.wb_valid_in = '0; bus.wb_rd_in = '0; flush = 1'b0;
    endtask
    task automatic enq(uop_t u, logic [3:0] rd, logic [3:0] rs1, logic [3:0] rs2);
        bus.dec_valid_in = 1'b1; bus.dec_uop_in = u; bus.dec_rd_in = rd; bus.dec_rs1_in = rs1; bus.dec_rs2_in = rs2;
    endtask
    task automatic predict();
        ent_t h;
        int k;
        logic [15:0] left;
        e_ready = q.size() < 4; e_iss = '0; e_deq = 1'b0; e_set = 1'b0; e_setrd = '0;
        if (q.size() > 0 && !flush) begin
            h = q[0];
            k = kind_of(h.uop);
            if (k < 5) begin
                if (!(h.uop.rs1_dependency && mb[h.rs1]) && !(h.uop.rs2_dependency && mb[h.rs2]) &&
                    !(h.uop.regfile_write && mb[h.rd]) && bus.unit_ready_in[k]) begin
                    e_iss[k] = 1'b1; e_deq = 1'b1;
                    e_set = h.uop.regfile_write && h.rd != 0; e_setrd = h.rd;
                end
            end else if (k == 6) e_deq = 1'b1;
            else begin
                left = mb;
                for (int p = 0; p < 2; p++) if (bus.wb_valid_in[p]) left[bus.wb_rd_in[p*4 +: 4]] = 1'b0;
                e_deq = left == 0 && lsu_idle;
            end
        end
        e_stall = q.size() > 0 && !flush && !e_deq;
    endtask
    task automatic commit();
        ent_t n;
        if (flush) q.delete();
        else begin
            if (e_deq) q.delete(0);
            if (bus.dec_valid_in && e_ready) begin
                n.uop = bus.dec_uop_in; n.rd = bus.dec_rd_in; n.rs1 = bus.dec_rs1_in; n.rs2 = bus.dec_rs2_in;
                q.push_back(n);
            end
        end
        for (int p = 0; p < 2; p++) if (bus.wb_valid_in[p]) mb[bus.wb_rd_in[p*4 +: 4]] = 1'b0;
        if (e_set) mb[e_setrd] = 1'b1;
    endtask
    task automatic adv();
        predict();
        @(posedge clk);
        commit();
        @(negedge clk);
    endtask

    task automatic test_reset();
        quiet(); bus.unit_ready_in = '0; lsu_idle = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; #1;
        ntot++; if (bus.iss_valid_out !== 5'b0) $display("FAIL reset_iss: got %b want 00000", bus.iss_valid_out); else npass++;
        ntot++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else npass++;
        ntot++; if (bus.dec_ready_out !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.dec_ready_out); else npass++;
        ntot++; if (busy !== 16'h0) $display("FAIL reset_busy: got %h want 0000", busy); else npass++;
    endtask
    task automatic test_alu();
        bus.unit_ready_in = '1;
        enq(mk(0, 1, 0, 0), 4'd3, 4'd1, 4'd2); #1;
        ntot++; if (bus.iss_valid_out !== 5'b0) $display("FAIL alu_nobypass: got %b want 00000", bus.iss_valid_out); else npass++;
        adv(); quiet(); #1;
        ntot++; if (bus.iss_valid_out !== 5'b00001) $display("FAIL alu_issue: got %b want 00001", bus.iss_valid_out); else npass++;
        ntot++; if (bus.iss_rd_out !== 4'd3) $display("FAIL alu_rd: got %0d want 3", bus.iss_rd_out); else npass++;
        adv();
        ntot++; if (busy !== 16'h0008) $display("FAIL alu_busy: got %h want 0008", busy); else npass++;
        bus.wb_valid_in = 2'b01; bus.wb_rd_in = 8'h03; #1; adv(); quiet();
        ntot++; if (busy !== 16'h0) $display("FAIL alu_wbclr: got %h want 0000", busy); else npass++;
    endtask
    task automatic test_raw();
        enq(mk(0, 1, 0, 0), 4'd5, 4'd0, 4'd0); #1; adv();
        enq(mk(0, 1, 1, 0), 4'd6, 4'd5, 4'd0); #1;
        ntot++; if (bus.iss_valid_out !== 5'b00001) $display("FAIL raw_first: got %b want 00001", bus.iss_valid_out); else npass++;
        adv(); quiet(); #1;
        ntot++; if (stall !== 1'b1 || bus.iss_valid_out !== 5'b0) $display("FAIL raw_stall: got %b/%b want 1/00000", stall, bus.iss_valid_out); else npass++;
        adv();
        bus.wb_valid_in = 2'b01; bus.wb_rd_in = 8'h05; #1;
        ntot++; if (stall !== 1'b1) $display("FAIL raw_wbcycle: got %b want 1", stall); else npass++;
        adv(); quiet(); #1;
        ntot++; if (bus.iss_valid_out !== 5'b00001 || stall !== 1'b0) $display("FAIL raw_release: got %b/%b want 00001/0", bus.iss_valid_out, stall); else npass++;
        ntot++; if (bus.iss_rs1_out !== 4'd5) $display("FAIL raw_rs1: got %0d want 5", bus.iss_rs1_out); else npass++;
        adv();
        bus.wb_valid_in = 2'b10; bus.wb_rd_in = 8'h60; #1; adv(); quiet();
        ntot++; if (busy !== 16'h0) $display("FAIL raw_clean: got %h want 0000", busy); else npass++;
    endtask
    task automatic test_fill_drain();
        logic [4:0] ex;
        bus.unit_ready_in = '0;
        for (int i = 0; i < 4; i++) begin
            enq(mk(i + 1, 0, 0, 0), 4'(8 + i), 4'(i), 4'(i)); #1;
            ntot++; if (bus.dec_ready_out !== 1'b1) $display("FAIL fill_ready%0d: got %b want 1", i, bus.dec_ready_out); else npass++;
            adv();
        end
        enq(mk(0, 1, 0, 0), 4'd1, 4'd0, 4'd0); #1;
        ntot++; if (bus.dec_ready_out !== 1'b0 || stall !== 1'b1) $display("FAIL fill_full: got %b/%b want 0/1", bus.dec_ready_out, stall); else npass++;
        adv(); quiet(); bus.unit_ready_in = '1;
        for (int i = 0; i < 4; i++) begin
            ex = 5'b00010 << i; #1;
            ntot++; if (bus.iss_valid_out !== ex || bus.iss_rd_out !== 4'(8 + i)) $display("FAIL drain%0d: got %b rd %0d want %b rd %0d", i, bus.iss_valid_out, bus.iss_rd_out, ex, 8 + i); else npass++;
            adv();
        end
        #1;
        ntot++; if (bus.dec_ready_out !== 1'b1 || stall !== 1'b0 || bus.iss_valid_out !== 5'b0) $display("FAIL drain_empty: got %b/%b/%b want 1/0/00000", bus.dec_ready_out, stall, bus.iss_valid_out); else npass++;
        ntot++; if (busy !== 16'h0) $display("FAIL drain_busy: got %h want 0000", busy); else npass++;
    endtask
    task automatic test_fence();
        bus.unit_ready_in = '1; lsu_idle = 1'b0;
        enq(mk(0, 1, 0, 0), 4'd7, 4'd0, 4'd0); #1; adv();
        enq(mk(5, 0, 0, 0), 4'd0, 4'd0, 4'd0); #1; adv();
        quiet(); #1;
        ntot++; if (stall !== 1'b1 || bus.iss_valid_out !== 5'b0 || busy !== 16'h0080) $display("FAIL fence_hold: got %b/%b/%h want 1/00000/0080", stall, bus.iss_valid_out, busy); else npass++;
        adv();
        lsu_idle = 1'b1; #1;
        ntot++; if (stall !== 1'b1) $display("FAIL fence_busyhold: got %b want 1", stall); else npass++;
        adv();
        bus.wb_valid_in = 2'b10; bus.wb_rd_in = 8'h70; #1;
        ntot++; if (stall !== 1'b0 || bus.iss_valid_out !== 5'b0) $display("FAIL fence_go: got %b/%b want 0/00000", stall, bus.iss_valid_out); else npass++;
        adv(); quiet(); lsu_idle = 1'b0; #1;
        ntot++; if (stall !== 1'b0 || busy !== 16'h0) $display("FAIL fence_after: got %b/%h want 0/0000", stall, busy); else npass++;
    endtask
    task automatic test_flush();
        bus.unit_ready_in = '1;
        enq(mk(0, 1, 0, 0), 4'd2, 4'd0, 4'd0); #1; adv();
        enq(mk(0, 0, 0, 0), 4'd9, 4'd0, 4'd0); #1; adv();
        bus.unit_ready_in = '0;
        enq(mk(0, 0, 0, 0), 4'd10, 4'd0, 4'd0); #1; adv();
        enq(mk(0, 0, 0, 0), 4'd11, 4'd0, 4'd0); #1; adv();
        quiet(); enq(mk(0, 0, 0, 0), 4'd13, 4'd0, 4'd0); flush = 1'b1; bus.unit_ready_in = '1; #1;
        ntot++; if (bus.iss_valid_out !== 5'b0 || stall !== 1'b0) $display("FAIL flush_cycle: got %b/%b want 00000/0", bus.iss_valid_out, stall); else npass++;
        adv(); quiet(); #1;
        ntot++; if (bus.iss_valid_out !== 5'b0 || stall !== 1'b0 || bus.dec_ready_out !== 1'b1) $display("FAIL flush_empty: got %b/%b/%b want 00000/0/1", bus.iss_valid_out, stall, bus.dec_ready_out); else npass++;
        ntot++; if (busy !== 16'h0004) $display("FAIL flush_busy: got %h want 0004", busy); else npass++;
        adv();
        bus.wb_valid_in = 2'b01; bus.wb_rd_in = 8'h02; #1; adv(); quiet();
    endtask
    task automatic test_set_wins();
        bus.unit_ready_in = '1;
        enq(mk(0, 1, 0, 0), 4'd4, 4'd0, 4'd0); #1; adv();
        quiet(); bus.wb_valid_in = 2'b01; bus.wb_rd_in = 8'h04; #1;
        ntot++; if (bus.iss_valid_out !== 5'b00001) $display("FAIL setwin_issue: got %b want 00001", bus.iss_valid_out); else npass++;
        adv(); quiet();
        ntot++; if (busy !== 16'h0010) $display("FAIL setwin_busy: got %h want 0010", busy); else npass++;
        bus.wb_valid_in = 2'b11; bus.wb_rd_in = 8'h44; #1; adv(); quiet();
        ntot++; if (busy !== 16'h0) $display("FAIL dualclr: got %h want 0000", busy); else npass++;
        enq(mk(0, 1, 0, 0), 4'd0, 4'd0, 4'd0); #1; adv(); quiet(); #1;
        ntot++; if (bus.iss_valid_out !== 5'b00001) $display("FAIL r0_issue: got %b want 00001", bus.iss_valid_out); else npass++;
        adv();
        ntot++; if (busy !== 16'h0) $display("FAIL r0_busy: got %h want 0000", busy); else npass++;
    endtask
    task automatic test_reset_mid();
        bus.unit_ready_in = '1;
        enq(mk(0, 1, 0, 0), 4'd9, 4'd0, 4'd0); #1; adv();
        enq(mk(1, 0, 0, 0), 4'd1, 4'd0, 4'd0); #1; adv();
        bus.unit_ready_in = '0;
        enq(mk(2, 0, 0, 0), 4'd2, 4'd0, 4'd0); #1; adv();
        quiet(); #2 rst = 1'b1; #1;
        ntot++; if (stall !== 1'b0 || bus.dec_ready_out !== 1'b1 || busy !== 16'h0) $display("FAIL midreset: got %b/%b/%h want 0/1/0000", stall, bus.dec_ready_out, busy); else npass++;
        q.delete(); mb = '0;
        @(negedge clk); rst = 1'b0;
    endtask
    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            quiet();
            if ($urandom_range(0, 2) != 0)
                enq(rand_uop(), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
            bus.unit_ready_in = 5'($urandom);
            bus.wb_valid_in = 2'($urandom);
            bus.wb_rd_in = {1'b0, 3'($urandom), 1'b0, 3'($urandom)};
            lsu_idle = 1'($urandom);
            flush = $urandom_range(0, 31) == 0;
            #1; predict();
            ntot++; if (bus.iss_valid_out !== e_iss) $display("FAIL rnd_iss@%0d: got %b want %b", n, bus.iss_valid_out, e_iss); else npass++;
            ntot++; if (stall !== e_stall) $display("FAIL rnd_stall@%0d: got %b want %b", n, stall, e_stall); else npass++;
            ntot++; if (bus.dec_ready_out !== e_ready) $display("FAIL rnd_ready@%0d: got %b want %b", n, bus.dec_ready_out, e_ready); else npass++;
            if (q.size() > 0) begin
                ntot++;
                if (bus.iss_uop_out !== q[0].uop || bus.iss_rd_out !== q[0].rd || bus.iss_rs1_out !== q[0].rs1 || bus.iss_rs2_out !== q[0].rs2)
                    $display("FAIL rnd_head@%0d: got %h/%0d/%0d/%0d want %h/%0d/%0d/%0d", n, bus.iss_uop_out, bus.iss_rd_out, bus.iss_rs1_out, bus.iss_rs2_out, q[0].uop, q[0].rd, q[0].rs1, q[0].rs2);
                else npass++;
            end
            @(posedge clk); commit(); @(negedge clk);
            ntot++; if (busy !== mb) $display("FAIL rnd_busy@%0d: got %h want %h", n, busy, mb); else npass++;
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_raw();
        test_fill_drain();
        test_fence();
        test_flush();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
